// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle instruction sequencer: opcodes,
// ALU operation codes, FSM state encoding and the default bus timeout.
package cpu_pkg;

  localparam int TIMEOUT_DEFAULT = 15;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_JZ    = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts not-ready cycles of a memory handshake; expired flags that the
// count has reached the tolerated limit.
module wait_timer
  import cpu_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LIMIT_W = 4'(LIMIT);

  logic [3:0] r_count;

  // Saturate at the limit; the sequencer aborts there, so wrapping is never wanted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign expired = (r_count == LIMIT_W);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: fetch, decode, execute, memory and write-back
// phases with a bus-timeout abort that latches a sticky error.
//
// state  | meaning
// IDLE   | waiting for run with no bus error; all controls low
// FETCH  | instruction fetch request held until imem_ready
// DECODE | one cycle; routes LOAD/STORE to MEM, others to EXEC
// EXEC   | ALU op select, or JZ branch resolution and retire
// MEM    | data access held until dmem_ready; STORE retires here
// WB     | register write-back from ALU or memory; retires
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_load,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] alu_op,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       instr_done,
  output logic       bus_err,
  output logic [2:0] state
);

  state_e     r_state;
  state_e     w_next;
  state_e     w_retire;
  logic [2:0] r_op;
  logic       r_bus_err;
  logic       w_waiting;
  logic       w_ready;
  logic       w_expired;
  logic       w_abort;
  logic       w_timer_clear;
  logic       w_timer_en;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ready   = ((r_state == S_FETCH) && imem_ready) ||
                     ((r_state == S_MEM)   && dmem_ready);
  assign w_abort   = w_waiting && !w_ready && w_expired;
  assign w_retire  = run ? S_FETCH : S_IDLE;

  // Counter restarts whenever a new handshake phase is entered.
  assign w_timer_clear = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);
  assign w_timer_en    = w_waiting && !w_ready;

  wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (run && !r_bus_err) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready)     w_next = S_DECODE;
        else if (w_expired) w_next = S_IDLE;
      end
      S_DECODE: begin
        w_next = is_mem_op(opcode) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        w_next = (r_op == OP_JZ) ? w_retire : S_WB;
      end
      S_MEM: begin
        if (dmem_ready)     w_next = (r_op == OP_STORE) ? w_retire : S_WB;
        else if (w_expired) w_next = S_IDLE;
      end
      S_WB: begin
        w_next = w_retire;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Opcode is captured in DECODE so later phases do not depend on the IR holding steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
      if (w_abort) r_bus_err <= 1'b1;
    end
  end

  // Handshake pulses must coincide with the ready cycle, so controls decode
  // the registered state together with the current inputs.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    alu_op     = ALU_ADD;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    pc_load    = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
      end
      S_EXEC: begin
        if (r_op == OP_JZ) begin
          pc_load    = zero;
          instr_done = 1'b1;
        end else begin
          alu_op = r_op;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_op == OP_STORE);
        if (dmem_ready && (r_op == OP_STORE)) instr_done = 1'b1;
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (r_op == OP_LOAD);
        alu_op     = (r_op == OP_LOAD) ? ALU_ADD : r_op;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_err = r_bus_err;
  assign state   = r_state;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the number of consecutive not-ready wait cycles tolerated in FETCH or MEM before abort.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enable; sequencing starts or continues while high.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction fetch completed.
- ir_load  out  1  load the instruction register.
- opcode  in  3  opcode from the instruction register: ADD=000, SUB=001, AND=010, OR=011, XOR=100, LOAD=101, STORE=110, JZ=111.
- zero  in  1  ALU zero flag.
- alu_op  out  3  ALU operation select.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable.
- dmem_ready  in  1  data memory access completed.
- reg_write  out  1  register file write enable.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory.
- pc_inc  out  1  increment the program counter.
- pc_load  out  1  load the branch target into the program counter.
- instr_done  out  1  instruction retired.
- bus_err  out  1  sticky bus-timeout flag.
- state  out  3  current state, for debug.

Function
REQ-003 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
REQ-004 IDLE: SHALL drive all outputs to 0 and go to FETCH when run=1 and bus_err=0.
REQ-005 FETCH: SHALL hold imem_req=1; in a cycle with imem_ready=1, SHALL pulse ir_load=1 and pc_inc=1 for that cycle and go to DECODE.
REQ-006 DECODE: SHALL last 1 cycle; opcodes 000-100 and JZ go to EXEC, LOAD and STORE go to MEM.
REQ-007 EXEC, ALU opcodes: SHALL drive alu_op equal to opcode, then go to WB.
REQ-008 EXEC, JZ: SHALL drive alu_op=000 and pulse pc_load=1 only if zero=1; SHALL pulse instr_done and go to the next state (REQ-012).
REQ-009 MEM: SHALL hold dmem_req=1, with dmem_we=1 only for STORE.
- The handshake completes in any MEM cycle with dmem_ready=1, including the first.
- LOAD then goes to WB.
- STORE pulses instr_done and goes to the next state (REQ-012).
REQ-010 WB: SHALL last 1 cycle with reg_write=1, wb_sel=1 for LOAD, wb_sel=0 for ALU ops and alu_op held; SHALL pulse instr_done.
REQ-011 reg_write and dmem_we SHALL never be 1 for STORE or JZ, and never be 1 outside WB or MEM respectively.
REQ-012 The next state after a retiring instruction SHALL be FETCH if run=1, else IDLE; when run falls mid-instruction, the instruction SHALL complete first.
REQ-013 Latency with ready in the first request cycle, FETCH entry to instr_done inclusive:
- ALU op and LOAD: 4 cycles.
- STORE and JZ: 3 cycles.
- Back-to-back instructions SHALL have no idle cycle between them.
REQ-014 Wait counter:
- 4-bit, cleared on entry to FETCH or MEM.
- Increments each FETCH or MEM cycle with ready=0.
- If ready=0 while the counter equals TIMEOUT, the FSM SHALL set bus_err=1, go to IDLE, and assert no instr_done, reg_write, pc_inc or ir_load.
- Ready asserted in that same cycle wins; no abort occurs.
REQ-015 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-016 instr_done, ir_load, pc_inc and pc_load SHALL each be a single-cycle pulse per instruction.

Reset
REQ-017 While rst=1 at a clock edge:
- state SHALL become IDLE, and the wait counter and bus_err SHALL become 0.
- All outputs SHALL read 0 in the following cycle.
REQ-018 Reset asserted mid-instruction SHALL abort that instruction with no further reg_write, dmem_req or PC update.
REQ-019 bus_err SHALL be cleared only by rst.

Structure
REQ-020 A shared package cpu_pkg SHALL hold the opcode constants, ALU op codes, the state encoding and the TIMEOUT default.
REQ-021 The 4-bit wait counter SHALL be a sub-module, wait_timer, with clear, enable and expired ports.

Verification
REQ-022 run=1, ADD (000), all readies immediate -> imem_req in cycle 1, alu_op=000 in cycle 3, reg_write=1 with wb_sel=0 and instr_done=1 in cycle 4, FETCH in cycle 5.
REQ-023 LOAD with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then WB with wb_sel=1 and reg_write=1.
REQ-024 JZ with zero=1, then JZ with zero=0 -> pc_load=1 only for the first; instr_done on both; reg_write=0 throughout.
REQ-025 STORE with dmem_ready never asserted -> bus_err=1 after 16 MEM cycles, FSM in IDLE, dmem_we dropped, no instr_done; run=1 stays in IDLE until rst.
REQ-026 rst=1 in the MEM cycle of a STORE -> next cycle state=0 and all outputs 0; after rst release with run=1, FETCH restarts.
